// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the RV32I multicycle sequencer and its datapath.
// Latency: n/a (wires only); the sequencer drives strobes combinationally from its state.
// Backpressure: mem_ready from memory stalls the sequencer in fetch and memory-access steps.
//
// Ports (master = sequencer, slave = datapath/memory side):
//   opcode, bcond, halt_cond, mem_ready           -> into the sequencer
//   mem_read, mem_write, i_or_d, ir_write,        <- memory / IR strobes
//   reg_write, wb_sel, alu_src_a, alu_src_b,      <- register file and ALU selects
//   alu_op_sel, pc_write, pc_source               <- ALU mode and PC update
//   instr_done, is_halted, cycle_count, inst_count<- status and performance counters
interface multicycle_control_fsm_if #(
  parameter int CNT_WIDTH = 32
);
  logic [6:0]           opcode;
  logic                 bcond;
  logic                 halt_cond;
  logic                 mem_ready;

  logic                 mem_read;
  logic                 mem_write;
  logic                 i_or_d;
  logic                 ir_write;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 alu_src_a;
  logic [1:0]           alu_src_b;
  logic                 alu_op_sel;
  logic                 pc_write;
  logic [1:0]           pc_source;
  logic                 instr_done;
  logic                 is_halted;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] inst_count;

  modport master (
    input  opcode, bcond, halt_cond, mem_ready,
    output mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel,
           alu_src_a, alu_src_b, alu_op_sel, pc_write, pc_source,
           instr_done, is_halted, cycle_count, inst_count
  );

  modport slave (
    output opcode, bcond, halt_cond, mem_ready,
    input  mem_read, mem_write, i_or_d, ir_write, reg_write, wb_sel,
           alu_src_a, alu_src_b, alu_op_sel, pc_write, pc_source,
           instr_done, is_halted, cycle_count, inst_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main IF/ID/EX/MEM/WB sequencer for the RV32I multicycle core; drives every datapath strobe.
// Latency: 2-5 cycles per instruction with mem_ready high; strobes are combinational from state.
// Backpressure: each mem_ready=0 cycle in IF or MEM holds the state and adds one cycle.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high; forces IF, clears counters and masks all outputs
//   bus    - multicycle_control_fsm_if.master: decode inputs, datapath strobes, counters
module multicycle_control_fsm #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MDR  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] SRCB_RS2 = 2'd0;
  localparam logic [1:0] SRCB_IMM = 2'd2;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op_sel;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       is_halted;
  } ctrl_t;

  state_t               state;
  state_t               state_nxt;
  ctrl_t                ctrl;
  logic [CNT_WIDTH-1:0] cycle_q;
  logic [CNT_WIDTH-1:0] inst_q;

  always_comb begin
    ctrl      = '0;
    state_nxt = state;
    case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        if (bus.mem_ready) begin
          ctrl.ir_write = 1'b1;
          state_nxt     = S_ID;
        end
      end
      S_ID: begin
        case (bus.opcode)
          OP_ECALL: begin
            if (bus.halt_cond) begin
              state_nxt = S_HALT;
            end else begin
              ctrl.pc_write   = 1'b1;
              ctrl.pc_source  = PC_PLUS4;
              ctrl.instr_done = 1'b1;
              state_nxt       = S_IF;
            end
          end
          OP_JAL: begin
            ctrl.reg_write  = 1'b1;
            ctrl.wb_sel     = WB_PC4;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_IMM;
            ctrl.instr_done = 1'b1;
            state_nxt       = S_IF;
          end
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: begin
            state_nxt = S_EX;
          end
          default: begin
            // Unrecognised opcodes retire as a NOP.
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_PLUS4;
            ctrl.instr_done = 1'b1;
            state_nxt       = S_IF;
          end
        endcase
      end
      S_EX: begin
        ctrl.alu_op_sel = 1'b1;
        ctrl.alu_src_b  = (bus.opcode == OP_R || bus.opcode == OP_BRANCH) ? SRCB_RS2 : SRCB_IMM;
        case (bus.opcode)
          OP_BRANCH: begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = bus.bcond ? PC_IMM : PC_PLUS4;
            ctrl.instr_done = 1'b1;
            state_nxt       = S_IF;
          end
          OP_JALR: begin
            // rd gets PC+4 of the old PC while PC loads the ALU target in the same edge.
            ctrl.reg_write  = 1'b1;
            ctrl.wb_sel     = WB_PC4;
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_ALU;
            ctrl.instr_done = 1'b1;
            state_nxt       = S_IF;
          end
          OP_LOAD, OP_STORE: state_nxt = S_MEM;
          OP_R, OP_I:        state_nxt = S_WB;
          default:           state_nxt = S_IF;
        endcase
      end
      S_MEM: begin
        ctrl.i_or_d = 1'b1;
        if (bus.opcode == OP_LOAD) begin
          ctrl.mem_read = 1'b1;
          if (bus.mem_ready) state_nxt = S_WB;
        end else if (bus.opcode == OP_STORE) begin
          ctrl.mem_write = 1'b1;
          if (bus.mem_ready) begin
            ctrl.pc_write   = 1'b1;
            ctrl.pc_source  = PC_PLUS4;
            ctrl.instr_done = 1'b1;
            state_nxt       = S_IF;
          end
        end else begin
          state_nxt = S_IF;
        end
      end
      S_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.wb_sel     = (bus.opcode == OP_LOAD) ? WB_MDR : WB_ALU;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_PLUS4;
        ctrl.instr_done = 1'b1;
        state_nxt       = S_IF;
      end
      S_HALT: begin
        ctrl.is_halted = 1'b1;
      end
      default: begin
        state_nxt = S_IF;
      end
    endcase
    // State is already IF during reset, but every strobe (including IF's mem_read) must be masked.
    if (reset) begin
      ctrl = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IF;
      cycle_q <= '0;
      inst_q  <= '0;
    end else begin
      state <= state_nxt;
      // Counts the edge that enters HALT, then freezes.
      if (state != S_HALT) begin
        cycle_q <= cycle_q + CNT_WIDTH'(1);
      end
      if (ctrl.instr_done) begin
        inst_q <= inst_q + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.mem_read    = ctrl.mem_read;
  assign bus.mem_write   = ctrl.mem_write;
  assign bus.i_or_d      = ctrl.i_or_d;
  assign bus.ir_write    = ctrl.ir_write;
  assign bus.reg_write   = ctrl.reg_write;
  assign bus.wb_sel      = ctrl.wb_sel;
  assign bus.alu_src_a   = ctrl.alu_src_a;
  assign bus.alu_src_b   = ctrl.alu_src_b;
  assign bus.alu_op_sel  = ctrl.alu_op_sel;
  assign bus.pc_write    = ctrl.pc_write;
  assign bus.pc_source   = ctrl.pc_source;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.is_halted   = ctrl.is_halted;
  assign bus.cycle_count = cycle_q;
  assign bus.inst_count  = inst_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle vector table plus a mid-instruction reset sequence.
// Latency: one table row per clock; inputs change 1 time unit after the rising edge.
// Backpressure: mem_ready is driven per row to exercise IF/MEM stalls.
module tb_multicycle_control_fsm;
  localparam int CW = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op_sel;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       is_halted;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic [6:0] op;
    logic       bc;
    logic       hc;
    logic       rdy;
    out_t       exp;
    int         cyc;
    int         inst;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[$];

  multicycle_control_fsm_if #(.CNT_WIDTH(CW)) bus ();
  multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.i_or_d     = bus.i_or_d;
    o.ir_write   = bus.ir_write;
    o.reg_write  = bus.reg_write;
    o.wb_sel     = bus.wb_sel;
    o.alu_src_a  = bus.alu_src_a;
    o.alu_src_b  = bus.alu_src_b;
    o.alu_op_sel = bus.alu_op_sel;
    o.pc_write   = bus.pc_write;
    o.pc_source  = bus.pc_source;
    o.instr_done = bus.instr_done;
    o.is_halted  = bus.is_halted;
    return o;
  endfunction

  function automatic void add(input string n, input logic r, input logic [6:0] op, input logic bc,
                              input logic hc, input logic rdy, input out_t e, input int c, input int i);
    vecs.push_back('{n, r, op, bc, hc, rdy, e, c, i});
  endfunction

  task automatic drive(input logic r, input logic [6:0] op, input logic bc, input logic hc, input logic rdy);
    reset         = r;
    bus.opcode    = op;
    bus.bcond     = bc;
    bus.halt_cond = hc;
    bus.mem_ready = rdy;
  endtask

  initial begin
    out_t z, if_w, if_s, ex_r, ex_i, wb_a, wb_l, mem_l, mem_sw, mem_sd;
    out_t br_t, br_n, jal_o, jalr_o, nxt, halt_o, act;

    z      = '0;
    if_w   = '{mem_read:1'b1, ir_write:1'b1, default:'0};
    if_s   = '{mem_read:1'b1, default:'0};
    ex_r   = '{alu_op_sel:1'b1, default:'0};
    ex_i   = '{alu_op_sel:1'b1, alu_src_b:2'd2, default:'0};
    wb_a   = '{reg_write:1'b1, pc_write:1'b1, instr_done:1'b1, default:'0};
    wb_l   = '{reg_write:1'b1, wb_sel:2'd1, pc_write:1'b1, instr_done:1'b1, default:'0};
    mem_l  = '{mem_read:1'b1, i_or_d:1'b1, default:'0};
    mem_sw = '{mem_write:1'b1, i_or_d:1'b1, default:'0};
    mem_sd = '{mem_write:1'b1, i_or_d:1'b1, pc_write:1'b1, instr_done:1'b1, default:'0};
    br_t   = '{alu_op_sel:1'b1, pc_write:1'b1, pc_source:2'd1, instr_done:1'b1, default:'0};
    br_n   = '{alu_op_sel:1'b1, pc_write:1'b1, instr_done:1'b1, default:'0};
    jal_o  = '{reg_write:1'b1, wb_sel:2'd2, pc_write:1'b1, pc_source:2'd1, instr_done:1'b1, default:'0};
    jalr_o = '{alu_op_sel:1'b1, alu_src_b:2'd2, reg_write:1'b1, wb_sel:2'd2, pc_write:1'b1,
               pc_source:2'd2, instr_done:1'b1, default:'0};
    nxt    = '{pc_write:1'b1, instr_done:1'b1, default:'0};
    halt_o = '{is_halted:1'b1, default:'0};

    //   name         rst op         bc    hc    rdy   expected cyc inst
    add("reset",      1, OP_R,      0, 0, 1, z,       0,  0);
    add("add_if",     0, OP_R,      0, 0, 1, if_w,    0,  0);
    add("add_id",     0, OP_R,      0, 0, 1, z,       1,  0);
    add("add_ex",     0, OP_R,      0, 0, 1, ex_r,    2,  0);
    add("add_wb",     0, OP_R,      0, 0, 1, wb_a,    3,  0);
    add("ld_if",      0, OP_LOAD,   0, 0, 1, if_w,    4,  1);
    add("ld_id",      0, OP_LOAD,   0, 0, 1, z,       5,  1);
    add("ld_ex",      0, OP_LOAD,   0, 0, 1, ex_i,    6,  1);
    add("ld_mem0",    0, OP_LOAD,   0, 0, 0, mem_l,   7,  1);
    add("ld_mem1",    0, OP_LOAD,   0, 0, 0, mem_l,   8,  1);
    add("ld_mem2",    0, OP_LOAD,   0, 0, 1, mem_l,   9,  1);
    add("ld_wb",      0, OP_LOAD,   0, 0, 1, wb_l,    10, 1);
    add("beq_t_if",   0, OP_BRANCH, 1, 0, 1, if_w,    11, 2);
    add("beq_t_id",   0, OP_BRANCH, 1, 0, 1, z,       12, 2);
    add("beq_t_ex",   0, OP_BRANCH, 1, 0, 1, br_t,    13, 2);
    add("beq_n_if",   0, OP_BRANCH, 0, 0, 1, if_w,    14, 3);
    add("beq_n_id",   0, OP_BRANCH, 0, 0, 1, z,       15, 3);
    add("beq_n_ex",   0, OP_BRANCH, 0, 0, 1, br_n,    16, 3);
    add("jal_if",     0, OP_JAL,    0, 0, 1, if_w,    17, 4);
    add("jal_id",     0, OP_JAL,    0, 0, 1, jal_o,   18, 4);
    add("jalr_if",    0, OP_JALR,   0, 0, 1, if_w,    19, 5);
    add("jalr_id",    0, OP_JALR,   0, 0, 1, z,       20, 5);
    add("jalr_ex",    0, OP_JALR,   0, 0, 1, jalr_o,  21, 5);
    add("ecall_if",   0, OP_ECALL,  0, 0, 1, if_w,    22, 6);
    add("ecall_id",   0, OP_ECALL,  0, 0, 1, nxt,     23, 6);
    add("nop_if_st",  0, OP_NOP,    0, 0, 0, if_s,    24, 7);
    add("nop_if",     0, OP_NOP,    0, 0, 1, if_w,    25, 7);
    add("nop_id",     0, OP_NOP,    0, 0, 1, nxt,     26, 7);
    add("st_if",      0, OP_STORE,  0, 0, 1, if_w,    27, 8);
    add("st_id",      0, OP_STORE,  0, 0, 1, z,       28, 8);
    add("st_ex",      0, OP_STORE,  0, 0, 1, ex_i,    29, 8);
    add("st_mem",     0, OP_STORE,  0, 0, 1, mem_sd,  30, 8);
    add("ori_if",     0, OP_I,      0, 0, 1, if_w,    31, 9);
    add("ori_id_nr",  0, OP_I,      0, 0, 0, z,       32, 9);
    add("ori_ex_nr",  0, OP_I,      0, 0, 0, ex_i,    33, 9);
    add("ori_wb_nr",  0, OP_I,      0, 0, 0, wb_a,    34, 9);
    add("reset2",     1, OP_ECALL,  0, 1, 1, z,       0,  0);
    add("halt_if",    0, OP_ECALL,  0, 1, 1, if_w,    0,  0);
    add("halt_id",    0, OP_ECALL,  0, 1, 1, z,       1,  0);
    for (int k = 0; k < 10; k++) begin
      add($sformatf("halt_%0d", k), 0, OP_ECALL, 0, logic'(k % 2), logic'((k / 2) % 2), halt_o, 2, 0);
    end

    drive(1'b1, OP_R, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].bc, vecs[i].hc, vecs[i].rdy);
      @(negedge clk);
      act = sample();
      chk({vecs[i].name, " outs"}, 64'(act), 64'(vecs[i].exp));
      chk({vecs[i].name, " cycle_count"}, 64'(bus.cycle_count), 64'(vecs[i].cyc));
      chk({vecs[i].name, " inst_count"}, 64'(bus.inst_count), 64'(vecs[i].inst));
      @(posedge clk); #1;
    end

    // Store stalled in MEM, then reset asserted asynchronously mid-cycle.
    drive(1'b1, OP_STORE, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, OP_STORE, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("st_stall outs", 64'(sample()), 64'(mem_sw));
    chk("st_stall cycle_count", 64'(bus.cycle_count), 64'(3));
    #2 reset = 1'b1;
    #1;
    chk("st_rst outs", 64'(sample()), 64'(z));
    chk("st_rst cycle_count", 64'(bus.cycle_count), 64'(0));
    chk("st_rst inst_count", 64'(bus.inst_count), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst outs", 64'(sample()), 64'(if_s));
    chk("post_rst cycle_count", 64'(bus.cycle_count), 64'(0));
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("post_rst2 outs", 64'(sample()), 64'(if_w));
    chk("post_rst2 cycle_count", 64'(bus.cycle_count), 64'(1));
    chk("post_rst2 inst_count", 64'(bus.inst_count), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main sequencer for the RV32I multicycle core. It steps each instruction through IF/ID/EX/MEM/WB and drives every datapath strobe: PC, IR, register-file and memory enables, mux selects, and the ALU-control mode select. It waits on a memory ready handshake and halts on ECALL when the halt condition is true. It also keeps cycle and retired-instruction counters for the bench.

Parameters:
CNT_WIDTH, 32, width of cycle_count and inst_count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
opcode  in  7  IR[6:0]; IR output, stable from ID until instr_done
bcond  in  1  branch-taken flag from ALU, valid in EX
halt_cond  in  1  ECALL with x17==10, from register file
mem_ready  in  1  memory completed access this cycle
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
i_or_d  out  1  0 = address from PC, 1 = address from ALUOut
ir_write  out  1  latch fetched word into IR
reg_write  out  1  register file write enable
wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = PC+4
alu_src_a  out  1  0 = rs1, 1 = PC
alu_src_b  out  2  0 = rs2, 1 = constant 4, 2 = immediate
alu_op_sel  out  1  0 = force ADD, 1 = use ALU control decode
pc_write  out  1  PC update enable
pc_source  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result (JALR)
instr_done  out  1  one-cycle pulse when an instruction retires
is_halted  out  1  high in HALT
cycle_count  out  CNT_WIDTH  cycles since reset, not counting halt
inst_count  out  CNT_WIDTH  retired instructions

Behaviour:
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Reset value is IF.
- While reset is high: all strobes and selects are 0, both counters are 0, and is_halted=0.
- Outputs are combinational from state, opcode, bcond and mem_ready. Any output not listed for a state is 0.
- IF: mem_read=1, i_or_d=0.
  - Stay in IF while mem_ready=0.
  - When mem_ready=1: ir_write=1, go to ID.
- ID, decode on opcode:
  - ECALL (1110011) with halt_cond=1: go to HALT, no pc_write.
  - ECALL with halt_cond=0: pc_write=1, pc_source=0, instr_done, go to IF.
  - JAL (1101111): reg_write=1, wb_sel=2, pc_write=1, pc_source=1, instr_done, go to IF.
  - R-type, I-type ALU, LOAD, STORE, BRANCH, JALR: go to EX.
  - Any other opcode is a NOP: pc_write=1, pc_source=0, instr_done, go to IF.
- EX: alu_op_sel=1 always.
  - alu_src_a=0 for all opcodes.
  - alu_src_b: 0 for R-type and BRANCH; 2 for I-type, LOAD, STORE, JALR.
  - BRANCH: pc_write=1, pc_source = bcond ? 1 : 0, instr_done, go to IF.
  - JALR: reg_write=1, wb_sel=2, pc_write=1, pc_source=2, instr_done, go to IF. PC+4 comes from the old PC, so the simultaneous rd/PC update is legal.
  - LOAD or STORE: go to MEM.
  - R-type or I-type: go to WB.
- MEM: i_or_d=1.
  - LOAD: mem_read=1; stay while mem_ready=0; on mem_ready go to WB. The datapath latches MDR on mem_ready.
  - STORE: mem_write=1; stay while mem_ready=0; on mem_ready: pc_write=1, pc_source=0, instr_done, go to IF.
- WB: reg_write=1, wb_sel = LOAD ? 1 : 0, pc_write=1, pc_source=0, instr_done, go to IF.
- HALT: absorbing until reset. is_halted=1, all strobes 0, counters frozen.
- Latencies with mem_ready tied high:
  - R-type/I-type: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH/JALR: 3 cycles.
  - JAL/ECALL/NOP: 2 cycles.
  - Each mem_ready=0 cycle in IF or MEM adds 1 cycle.
- Counters:
  - cycle_count increments every clock edge outside reset where the state is not HALT, including the edge that enters HALT.
  - inst_count increments on each edge where instr_done=1.
  - Both wrap modulo 2^CNT_WIDTH.
- Reset asserted mid-instruction (e.g. in MEM with mem_write high): state goes to IF immediately and outputs go to 0 in the same cycle. No partial retire is counted.
- mem_ready outside IF/MEM is ignored.

Test Plan:
- ADD (0110011), mem_ready=1 from reset release → states 0,1,2,4,0. WB cycle: reg_write=1, wb_sel=0, pc_write=1, pc_source=0, instr_done=1. inst_count=1, cycle_count=4.
- LOAD (0000011), mem_ready low for 2 cycles in MEM → MEM held 3 cycles with mem_read=1 and i_or_d=1. Then WB with wb_sel=1. 7 cycles total.
- BEQ (1100011), bcond=1 → EX: pc_write=1, pc_source=1, alu_src_b=0. Repeat with bcond=0 → pc_source=0. 3 cycles each.
- JAL then JALR → JAL retires in ID with wb_sel=2, pc_source=1 (2 cycles). JALR retires in EX with reg_write=1, pc_source=2, alu_src_b=2.
- ECALL with halt_cond=1 → HALT after ID, is_halted=1. cycle_count stays at 2 and mem_read stays 0 for 10 further cycles. ECALL with halt_cond=0 → pc_source=0, back to IF.
- STORE with mem_ready=0, reset pulsed in MEM → mem_write drops in the same cycle and counters read 0. After release, state=IF with mem_read=1.
